// File: rtl/mm_arb_pkg.sv
// Shared types and helpers for the two-master bus_MM arbiter.
// Holds the ownership state encoding, idle bus values and the tie-break rule.
package mm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] IDLE_ADDR = 8'd99;
    localparam logic [7:0] IDLE_DATA = 8'd99;

    // Round-robin pick: a tie goes to the master that was not granted last.
    function automatic arb_state_t next_owner(input logic req0,
                                              input logic req1,
                                              input logic last_gnt);
        arb_state_t nxt;
        nxt = IDLE;
        if (req0 && req1) begin
            nxt = last_gnt ? OWN0 : OWN1;
        end else if (req0) begin
            nxt = OWN0;
        end else if (req1) begin
            nxt = OWN1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mm_arb_mux.sv
// Combinational owner-select mux: routes the owning master to the slave and
// generates per-master waitrequest; idle values are driven when nobody owns.
module mm_arb_mux
    import mm_arb_pkg::*;
#(
    parameter int         AW            = 8,
    parameter int         DW            = 8,
    parameter logic [7:0] IDLE_ADDR_VAL = IDLE_ADDR,
    parameter logic [7:0] IDLE_DATA_VAL = IDLE_DATA
) (
    input  arb_state_t    owner,
    input  logic [AW-1:0] m0_address,
    input  logic          m0_write,
    input  logic          m0_read,
    input  logic [DW-1:0] m0_writedata,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_waitrequest,
    input  logic [AW-1:0] m1_address,
    input  logic          m1_write,
    input  logic          m1_read,
    input  logic [DW-1:0] m1_writedata,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_waitrequest,
    output logic [AW-1:0] s_address,
    output logic          s_write,
    output logic          s_read,
    output logic [DW-1:0] s_writedata,
    input  logic [DW-1:0] s_readdata,
    input  logic          s_waitrequest
);

    always_comb begin
        s_address      = AW'(IDLE_ADDR_VAL);
        s_writedata    = DW'(IDLE_DATA_VAL);
        s_write        = 1'b0;
        s_read         = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        // A simultaneous write+read is illegal; the write wins.
        case (owner)
            OWN0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_write        = m0_write;
                s_read         = m0_read & ~m0_write;
                m0_waitrequest = s_waitrequest;
            end
            OWN1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the owner's completion cycle is meaningful.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: rtl/mm_arbiter_2to1.sv
// Two-master round-robin arbiter for the bus_MM memory-mapped bus.
// Define MM_ARB_LOCK_EN to add m0_lock/m1_lock for back-to-back locked transfers.
module mm_arbiter_2to1
    import mm_arb_pkg::*;
#(
    parameter int         AW       = 8,
    parameter int         DW       = 8,
    parameter logic [7:0] IDLE_VAL = IDLE_ADDR
) (
    input  logic          CLK,
    input  logic          reset,
`ifdef MM_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    input  logic [AW-1:0] m0_address,
    input  logic          m0_write,
    input  logic          m0_read,
    input  logic [DW-1:0] m0_writedata,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_waitrequest,
    input  logic [AW-1:0] m1_address,
    input  logic          m1_write,
    input  logic          m1_read,
    input  logic [DW-1:0] m1_writedata,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_waitrequest,
    output logic [AW-1:0] s_address,
    output logic          s_write,
    output logic          s_read,
    output logic [DW-1:0] s_writedata,
    input  logic [DW-1:0] s_readdata,
    input  logic          s_waitrequest
);

    arb_state_t state, state_nxt, owner;
    logic       last_gnt, last_gnt_nxt;
    logic       m0_req, m1_req;
    logic       lock0, lock1;

    assign m0_req = m0_write | m0_read;
    assign m1_req = m1_write | m1_read;

`ifdef MM_ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Owner releases to the other master if it is waiting, else to IDLE;
    // a stalled owner (request held, waitrequest high) is never preempted.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: state_nxt = next_owner(m0_req, m1_req, last_gnt);
            OWN0: begin
                if (!m0_req) begin
                    state_nxt = next_owner(1'b0, m1_req, last_gnt);
                end else if (!s_waitrequest) begin
                    last_gnt_nxt = 1'b0;
                    if (!lock0) state_nxt = next_owner(1'b0, m1_req, 1'b0);
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_nxt = next_owner(m0_req, 1'b0, last_gnt);
                end else if (!s_waitrequest) begin
                    last_gnt_nxt = 1'b1;
                    if (!lock1) state_nxt = next_owner(m0_req, 1'b0, 1'b1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces idle bus values immediately, even mid-transfer.
    assign owner = reset ? IDLE : state;

    mm_arb_mux #(
        .AW            (AW),
        .DW            (DW),
        .IDLE_ADDR_VAL (IDLE_VAL),
        .IDLE_DATA_VAL (IDLE_VAL)
    ) u_mux (
        .owner          (owner),
        .m0_address     (m0_address),
        .m0_write       (m0_write),
        .m0_read        (m0_read),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_write       (m1_write),
        .m1_read        (m1_read),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
    );

endmodule

// File: tb/tb_mm_arbiter_2to1.sv
// Directed self-checking bench for mm_arbiter_2to1 (lock scenario only when
// MM_ARB_LOCK_EN is defined).
module tb_mm_arbiter_2to1;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          reset;
`ifdef MM_ARB_LOCK_EN
    logic          m0_lock, m1_lock;
`endif
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_write, m0_read, m1_write, m1_read;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          s_write, s_read, s_waitrequest;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mm_arbiter_2to1 #(.AW(AW), .DW(DW), .IDLE_VAL(8'd99)) dut (
        .CLK            (CLK),
        .reset          (reset),
`ifdef MM_ARB_LOCK_EN
        .m0_lock        (m0_lock),
        .m1_lock        (m1_lock),
`endif
        .m0_address     (m0_address),
        .m0_write       (m0_write),
        .m0_read        (m0_read),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_write       (m1_write),
        .m1_read        (m1_read),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
    );

    // Snapshot layout: {s_write, s_read, s_address, s_writedata, m0_wait, m1_wait}
    localparam logic [19:0] IDLE_SNAP = {1'b0, 1'b0, 8'd99, 8'd99, 1'b1, 1'b1};
    localparam logic [19:0] M0_SNAP   = {1'b1, 1'b0, 8'h10, 8'hA0, 1'b0, 1'b1};
    localparam logic [19:0] M1_SNAP   = {1'b1, 1'b0, 8'h20, 8'hB0, 1'b1, 1'b0};

    function automatic logic [19:0] snap();
        return {s_write, s_read, s_address, s_writedata, m0_waitrequest, m1_waitrequest};
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        m0_write = 1'b0; m0_read = 1'b0; m0_address = '0; m0_writedata = '0;
        m1_write = 1'b0; m1_read = 1'b0; m1_address = '0; m1_writedata = '0;
`ifdef MM_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic go_idle();
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        reset = 1'b1;
        clear_inputs();
        s_waitrequest = 1'b0;
        s_readdata    = '0;
        m0_write = 1'b1; m0_address = 8'h05; m0_writedata = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #2;
            n_checks++;
            if (snap() !== IDLE_SNAP) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, snap(), IDLE_SNAP);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (snap() !== IDLE_SNAP) begin
            n_fail++;
            $display("FAIL reset_arb_cycle: got %h expected %h", snap(), IDLE_SNAP);
        end
        next_cycle(); #1;
        exp = {1'b1, 1'b0, 8'h05, 8'h05, 1'b0, 1'b1};
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h expected %h", snap(), exp);
        end
        go_idle();
    endtask

    task automatic test_single_write();
        logic [19:0] exp;
        next_cycle();
        m0_write = 1'b1; m0_address = 8'h05; m0_writedata = 8'h05;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin next_cycle(); #1; end
            exp = (i % 2 == 1) ? {1'b1, 1'b0, 8'h05, 8'h05, 1'b0, 1'b1} : IDLE_SNAP;
            n_checks++;
            if (snap() !== exp) begin
                n_fail++;
                $display("FAIL single_write[%0d]: got %h expected %h", i, snap(), exp);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        do_reset();
        next_cycle();
        m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 8'hA0;
        m1_write = 1'b1; m1_address = 8'h20; m1_writedata = 8'hB0;
        s_waitrequest = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin next_cycle(); #1; end
            exp = (i == 0) ? IDLE_SNAP : ((i % 2 == 1) ? M0_SNAP : M1_SNAP);
            n_checks++;
            if (snap() !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, snap(), exp);
            end
        end
        go_idle();
    endtask

    task automatic test_wait_hold();
        logic [19:0] exp;
        next_cycle();
        m1_write = 1'b1; m1_address = 8'h20; m1_writedata = 8'hB0;
        s_waitrequest = 1'b1;
        next_cycle();
        m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 8'hA0;
        #1;
        exp = {1'b1, 1'b0, 8'h20, 8'hB0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin next_cycle(); #1; end
            n_checks++;
            if (snap() !== exp) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: got %h expected %h", i, snap(), exp);
            end
        end
        next_cycle();
        s_waitrequest = 1'b0;
        #1;
        n_checks++;
        if (snap() !== M1_SNAP) begin
            n_fail++;
            $display("FAIL wait_release: got %h expected %h", snap(), M1_SNAP);
        end
        next_cycle();
        m1_write = 1'b0;
        #1;
        n_checks++;
        if (snap() !== M0_SNAP) begin
            n_fail++;
            $display("FAIL wait_next_grant: got %h expected %h", snap(), M0_SNAP);
        end
        go_idle();
    endtask

    task automatic test_read();
        logic [19:0] exp;
        next_cycle();
        m0_read = 1'b1; m0_address = 8'h33; s_readdata = 8'hA5; s_waitrequest = 1'b0;
        #1;
        n_checks++;
        if (snap() !== IDLE_SNAP) begin
            n_fail++;
            $display("FAIL read_arb_cycle: got %h expected %h", snap(), IDLE_SNAP);
        end
        next_cycle(); #1;
        exp = {1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 1'b1};
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL read_grant: got %h expected %h", snap(), exp);
        end
        n_checks++;
        if (m0_readdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_m0_data: got %h expected a5", m0_readdata);
        end
        n_checks++;
        if (m1_readdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_m1_broadcast: got %h expected a5", m1_readdata);
        end
        next_cycle();
        m0_write = 1'b1; m0_writedata = 8'h5A;
        next_cycle(); #1;
        exp = {1'b1, 1'b0, 8'h33, 8'h5A, 1'b0, 1'b1};
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL write_precedence: got %h expected %h", snap(), exp);
        end
        go_idle();
    endtask

    task automatic test_drop();
        logic [19:0] exp;
        next_cycle();
        m1_write = 1'b1; m1_address = 8'h20; m1_writedata = 8'hB0;
        s_waitrequest = 1'b1;
        next_cycle(); #1;
        exp = {1'b1, 1'b0, 8'h20, 8'hB0, 1'b1, 1'b1};
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL drop_stalled_owner: got %h expected %h", snap(), exp);
        end
        next_cycle();
        m1_write = 1'b0;
        #1;
        exp = {1'b0, 1'b0, 8'h20, 8'hB0, 1'b1, 1'b1};
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL drop_cycle: got %h expected %h", snap(), exp);
        end
        next_cycle();
        m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 8'hA0;
        m1_write = 1'b1; m1_address = 8'h20; m1_writedata = 8'hB0;
        s_waitrequest = 1'b0;
        #1;
        n_checks++;
        if (snap() !== IDLE_SNAP) begin
            n_fail++;
            $display("FAIL drop_released: got %h expected %h", snap(), IDLE_SNAP);
        end
        // m0 completed last and the abandoned m1 transfer must not count.
        next_cycle(); #1;
        n_checks++;
        if (snap() !== M1_SNAP) begin
            n_fail++;
            $display("FAIL drop_tie_m1: got %h expected %h", snap(), M1_SNAP);
        end
        next_cycle(); #1;
        n_checks++;
        if (snap() !== M0_SNAP) begin
            n_fail++;
            $display("FAIL drop_tie_m0: got %h expected %h", snap(), M0_SNAP);
        end
        go_idle();
    endtask

`ifdef MM_ARB_LOCK_EN
    task automatic test_lock();
        logic [19:0] exp;
        do_reset();
        next_cycle();
        m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 8'hA0; m0_lock = 1'b1;
        m1_write = 1'b1; m1_address = 8'h20; m1_writedata = 8'hB0;
        s_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 2) m0_lock = 1'b0;
            #1;
            exp = (i < 3) ? M0_SNAP : M1_SNAP;
            n_checks++;
            if (snap() !== exp) begin
                n_fail++;
                $display("FAIL lock[%0d]: got %h expected %h", i, snap(), exp);
            end
        end
        go_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_hold();
        test_read();
        test_drop();
`ifdef MM_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
